// File: rtl/nfca_poll_if.sv
// Handshake and stream bundle between the NFC-A poll sequencer (master side),
// the host command logic and the NFC-A TX/RX byte streams (slave side).
interface nfca_poll_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic [15:0] atqa;
    logic [31:0] uid;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [7:0]  tx_tdata;
    logic [3:0]  tx_tdatab;
    logic        tx_tlast;
    logic        rx_tvalid;
    logic [7:0]  rx_tdata;
    logic [3:0]  rx_tdatab;
    logic        rx_tend;
    logic        rx_terr;

    modport master (
        input  start, tx_tready, rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr,
        output busy, done, result, atqa, uid, tx_tvalid, tx_tdata, tx_tdatab, tx_tlast
    );

    modport slave (
        output start, tx_tready, rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr,
        input  busy, done, result, atqa, uid, tx_tvalid, tx_tdata, tx_tdatab, tx_tlast
    );
endinterface

// File: rtl/nfca_poll_sequencer.sv
// ISO14443-A card-detect sequencer: REQA -> ATQA -> guard -> ANTICOLLISION CL1 -> UID+BCC.
// state     | meaning
// IDLE      | waiting for start
// TX_REQA   | presenting the 7-bit REQA frame
// WAIT_ATQA | collecting ATQA, timeout running
// GUARD     | idle gap before ANTICOLLISION
// TX_AC     | presenting 0x93 0x20
// WAIT_UID  | collecting UID CL1 + BCC, timeout running
// DONE      | one-cycle completion pulse
module nfca_poll_sequencer #(
    parameter int TIMEOUT_CYC = 81360,
    parameter int GUARD_CYC   = 8136
) (
    input logic         clk,
    input logic         rst,
    nfca_poll_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GRD_LAST = GW'(GUARD_CYC - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TX_REQA   = 3'd1;
    localparam logic [2:0] S_WAIT_ATQA = 3'd2;
    localparam logic [2:0] S_GUARD     = 3'd3;
    localparam logic [2:0] S_TX_AC     = 3'd4;
    localparam logic [2:0] S_WAIT_UID  = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            bad_q, bad_d;
    logic            ac_beat_q, ac_beat_d;
    logic [4:0][7:0] rxb_q, rxb_d;
    logic [1:0]      result_q, result_d;
    logic [15:0]     atqa_q, atqa_d;
    logic [31:0]     uid_q, uid_d;

    logic            tx_valid;
    logic [7:0]      tx_data;
    logic [3:0]      tx_datab;
    logic            tx_last;
    logic            tx_fire;
    logic [2:0]      cnt_nx;
    logic            bad_nx;
    logic [4:0][7:0] rxb_nx;
    logic [7:0]      bcc;

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_datab = 4'd0;
        tx_last  = 1'b0;
        case (state_q)
            S_TX_REQA: begin
                tx_valid = 1'b1;
                tx_data  = 8'h26;
                tx_datab = 4'd7;
                tx_last  = 1'b1;
            end
            S_TX_AC: begin
                tx_valid = 1'b1;
                tx_data  = ac_beat_q ? 8'h20 : 8'h93;
                tx_datab = 4'd8;
                tx_last  = ac_beat_q;
            end
            default: ;
        endcase
    end

    assign tx_fire = tx_valid & bus.tx_tready;

    // The frame-end beat may carry the last byte, so decisions use the post-beat view.
    always_comb begin
        cnt_nx = cnt_q;
        bad_nx = bad_q;
        rxb_nx = rxb_q;
        if (bus.rx_tvalid) begin
            for (int i = 0; i < 5; i++) begin
                if (cnt_q == 3'(i)) rxb_nx[i] = bus.rx_tdata;
            end
            if (cnt_q != 3'd7) cnt_nx = cnt_q + 3'd1;
            if (bus.rx_tdatab != 4'd8) bad_nx = 1'b1;
        end
        bcc = rxb_nx[0] ^ rxb_nx[1] ^ rxb_nx[2] ^ rxb_nx[3];
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        guard_d   = guard_q;
        cnt_d     = cnt_q;
        bad_d     = bad_q;
        ac_beat_d = ac_beat_q;
        rxb_d     = rxb_q;
        result_d  = result_q;
        atqa_d    = atqa_q;
        uid_d     = uid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_TX_REQA;
                    result_d = 2'd0;
                    atqa_d   = 16'h0000;
                    uid_d    = 32'h0000_0000;
                end
            end
            S_TX_REQA: begin
                if (tx_fire) begin
                    timer_d = '0;
                    cnt_d   = 3'd0;
                    bad_d   = 1'b0;
                    state_d = S_WAIT_ATQA;
                end
            end
            S_WAIT_ATQA, S_WAIT_UID: begin
                cnt_d   = cnt_nx;
                bad_d   = bad_nx;
                rxb_d   = rxb_nx;
                timer_d = (timer_q == TMO_MAX) ? timer_q : timer_q + TW'(1);
                if (bus.rx_tend) begin
                    state_d = S_DONE;
                    if (bus.rx_terr) begin
                        result_d = 2'd2;
                    end else if (state_q == S_WAIT_ATQA) begin
                        if (cnt_nx == 3'd2 && !bad_nx) begin
                            atqa_d  = {rxb_nx[1], rxb_nx[0]};
                            guard_d = '0;
                            state_d = S_GUARD;
                        end else begin
                            result_d = 2'd2;
                        end
                    end else if (cnt_nx != 3'd5 || bad_nx) begin
                        result_d = 2'd2;
                    end else if (bcc != rxb_nx[4]) begin
                        result_d = 2'd3;
                    end else begin
                        result_d = 2'd0;
                        uid_d    = {rxb_nx[3], rxb_nx[2], rxb_nx[1], rxb_nx[0]};
                    end
                end else if (timer_q == TMO_LAST) begin
                    result_d = 2'd1;
                    state_d  = S_DONE;
                end
            end
            S_GUARD: begin
                guard_d = guard_q + GW'(1);
                if (guard_q == GRD_LAST) begin
                    ac_beat_d = 1'b0;
                    state_d   = S_TX_AC;
                end
            end
            S_TX_AC: begin
                if (tx_fire) begin
                    if (!ac_beat_q) begin
                        ac_beat_d = 1'b1;
                    end else begin
                        ac_beat_d = 1'b0;
                        timer_d   = '0;
                        cnt_d     = 3'd0;
                        bad_d     = 1'b0;
                        state_d   = S_WAIT_UID;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            guard_q   <= '0;
            cnt_q     <= 3'd0;
            bad_q     <= 1'b0;
            ac_beat_q <= 1'b0;
            rxb_q     <= '0;
            result_q  <= 2'd0;
            atqa_q    <= 16'h0000;
            uid_q     <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            guard_q   <= guard_d;
            cnt_q     <= cnt_d;
            bad_q     <= bad_d;
            ac_beat_q <= ac_beat_d;
            rxb_q     <= rxb_d;
            result_q  <= result_d;
            atqa_q    <= atqa_d;
            uid_q     <= uid_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.atqa      = atqa_q;
    assign bus.uid       = uid_q;
    assign bus.tx_tvalid = tx_valid;
    assign bus.tx_tdata  = tx_data;
    assign bus.tx_tdatab = tx_datab;
    assign bus.tx_tlast  = tx_last;
endmodule

// File: tb/tb_nfca_poll_sequencer.sv
// Bench for nfca_poll_sequencer: scenario tasks drive randomized card responses and
// compare against a transaction-level model of the ISO14443-A detect outcome.
module tb_nfca_poll_sequencer;
    localparam int TMO = 300;
    localparam int GRD = 20;
    localparam int LIM = TMO + GRD + 100;
    localparam logic [13:0] EXP_REQA = {1'b1, 8'h26, 4'd7, 1'b1};
    localparam logic [13:0] EXP_AC0  = {1'b1, 8'h93, 4'd8, 1'b0};
    localparam logic [13:0] EXP_AC1  = {1'b1, 8'h20, 4'd8, 1'b1};

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [13:0] reqa;
        logic        busy1;
        int          cyc1;
        logic [13:0] ac0;
        logic [13:0] ac1;
        bit          ok;
        logic [1:0]  r;
        logic [15:0] a;
        logic [31:0] u;
        logic        busy_at_done;
        logic        done_after;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    nfca_poll_if bus();

    nfca_poll_sequencer #(.TIMEOUT_CYC(TMO), .GUARD_CYC(GRD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] tx_now();
        return {bus.tx_tvalid, bus.tx_tdata, bus.tx_tdatab, bus.tx_tlast};
    endfunction

    function automatic logic [65:0] outs_now();
        return {bus.busy, bus.done, bus.result, bus.atqa, bus.uid,
                bus.tx_tvalid, bus.tx_tdata, bus.tx_tdatab, bus.tx_tlast};
    endfunction

    // Outcome of a whole transaction from the card's responses alone.
    function automatic void model(input bq_t aq, input int abad, input bit aerr,
                                  input bq_t uq, input int ubad, input bit uerr,
                                  output logic [1:0] r, output logic [15:0] a,
                                  output logic [31:0] u);
        a = 16'h0;
        u = 32'h0;
        r = 2'd0;
        if (aq.size() == 0 && !aerr) r = 2'd1;
        else if (aerr || (abad >= 0 && abad < aq.size()) || aq.size() != 2) r = 2'd2;
        else begin
            a = {aq[1], aq[0]};
            if (uq.size() == 0 && !uerr) r = 2'd1;
            else if (uerr || (ubad >= 0 && ubad < uq.size()) || uq.size() != 5) r = 2'd2;
            else if ((uq[0] ^ uq[1] ^ uq[2] ^ uq[3]) != uq[4]) r = 2'd3;
            else begin
                r = 2'd0;
                u = {uq[3], uq[2], uq[1], uq[0]};
            end
        end
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.tx_tready = 1'b0;
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata  = 8'h00;
        bus.rx_tdatab = 4'd0;
        bus.rx_tend   = 1'b0;
        bus.rx_terr   = 1'b0;
    endtask

    task automatic send_rx(input bq_t q, input int bad, input bit err, input bit tend_last);
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.rx_tvalid = 1'b1;
            bus.rx_tdata  = q[i];
            bus.rx_tdatab = (i == bad) ? 4'd4 : 4'd8;
            if (tend_last && i == q.size() - 1) begin
                bus.rx_tend = 1'b1;
                bus.rx_terr = err;
            end
            @(posedge clk); #1;
            idle_inputs();
        end
        if (!tend_last || q.size() == 0) begin
            bus.rx_tend = 1'b1;
            bus.rx_terr = err;
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    task automatic wait_for(input bit want_tx, output int cyc);
        cyc = 0;
        while (!(bus.done || (want_tx && bus.tx_tvalid)) && cyc < LIM) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic accept_ac(output logic [13:0] ac0, output logic [13:0] ac1);
        ac0 = tx_now();
        bus.tx_tready = 1'b1;
        @(posedge clk); #1;
        ac1 = tx_now();
        if ($urandom_range(0, 1) == 0) begin
            bus.tx_tready = 1'b0;
            @(posedge clk); #1;
            bus.tx_tready = 1'b1;
        end
        @(posedge clk); #1;
        bus.tx_tready = 1'b0;
    endtask

    task automatic run_txn(input bq_t aq, input int abad, input bit aerr,
                           input bq_t uq, input int ubad, input bit uerr, output obs_t o);
        int c2;
        o.ac0 = '0;
        o.ac1 = '0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        o.reqa  = tx_now();
        o.busy1 = bus.busy;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bus.tx_tready = 1'b1;
        @(posedge clk); #1;
        bus.tx_tready = 1'b0;
        if (aq.size() > 0 || aerr) send_rx(aq, abad, aerr, 1'($urandom_range(0, 1)));
        wait_for(1'b1, o.cyc1);
        if (bus.tx_tvalid && !bus.done) begin
            accept_ac(o.ac0, o.ac1);
            if (uq.size() > 0 || uerr) send_rx(uq, ubad, uerr, 1'($urandom_range(0, 1)));
            wait_for(1'b0, c2);
        end
        o.ok           = bus.done;
        o.r            = bus.result;
        o.a            = bus.atqa;
        o.u            = bus.uid;
        o.busy_at_done = bus.busy;
        @(posedge clk); #1;
        o.done_after = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (outs_now() !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs_now());
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_card();
        bq_t e;
        obs_t o;
        run_txn(e, -1, 1'b0, e, -1, 1'b0, o);
        checks++;
        if (o.reqa !== EXP_REQA || o.busy1 !== 1'b1) begin
            errors++;
            $display("FAIL no_card_reqa: got %h busy %b want %h busy 1", o.reqa, o.busy1, EXP_REQA);
        end
        checks++;
        if (o.cyc1 !== TMO || !o.ok) begin
            errors++;
            $display("FAIL no_card_timeout_cycles: got %0d done %b want %0d", o.cyc1, o.ok, TMO);
        end
        checks++;
        if (o.r !== 2'd1 || o.a !== 16'h0 || o.u !== 32'h0) begin
            errors++;
            $display("FAIL no_card_result: got r=%0d atqa=%h uid=%h want r=1 atqa=0 uid=0", o.r, o.a, o.u);
        end
        checks++;
        if (o.busy_at_done !== 1'b0 || o.done_after !== 1'b0) begin
            errors++;
            $display("FAIL no_card_done_pulse: got busy@done=%b done_next=%b want 0 0", o.busy_at_done, o.done_after);
        end
    endtask

    task automatic test_good_card();
        bq_t aq = '{8'h04, 8'h00};
        bq_t uq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        obs_t o;
        logic [1:0] er; logic [15:0] ea; logic [31:0] eu;
        model(aq, -1, 1'b0, uq, -1, 1'b0, er, ea, eu);
        run_txn(aq, -1, 1'b0, uq, -1, 1'b0, o);
        checks++;
        if (o.cyc1 !== GRD) begin
            errors++;
            $display("FAIL good_card_guard: got %0d cycles want %0d", o.cyc1, GRD);
        end
        checks++;
        if (o.ac0 !== EXP_AC0 || o.ac1 !== EXP_AC1) begin
            errors++;
            $display("FAIL good_card_ac_beats: got %h %h want %h %h", o.ac0, o.ac1, EXP_AC0, EXP_AC1);
        end
        checks++;
        if (!o.ok || o.r !== er || o.a !== ea || o.u !== eu || eu !== 32'h44332211) begin
            errors++;
            $display("FAIL good_card_result: got done=%b r=%0d atqa=%h uid=%h want r=%0d atqa=%h uid=%h",
                     o.ok, o.r, o.a, o.u, er, ea, eu);
        end
    endtask

    task automatic test_bcc_wrong();
        bq_t aq = '{8'h04, 8'h00};
        bq_t uq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        obs_t o;
        logic [1:0] er; logic [15:0] ea; logic [31:0] eu;
        model(aq, -1, 1'b0, uq, -1, 1'b0, er, ea, eu);
        run_txn(aq, -1, 1'b0, uq, -1, 1'b0, o);
        checks++;
        if (!o.ok || o.r !== er || o.a !== ea || o.u !== eu) begin
            errors++;
            $display("FAIL bcc_wrong: got done=%b r=%0d atqa=%h uid=%h want r=%0d atqa=%h uid=%h",
                     o.ok, o.r, o.a, o.u, er, ea, eu);
        end
    endtask

    task automatic test_errors();
        for (int k = 0; k < 3; k++) begin
            bq_t aq, uq;
            int abad;
            bit uerr;
            obs_t o;
            logic [1:0] er; logic [15:0] ea; logic [31:0] eu;
            aq = '{8'h04, 8'h00};
            uq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
            abad = -1;
            uerr = 1'b0;
            case (k)
                0: uerr = 1'b1;
                1: aq.push_back(8'h01);
                default: abad = 0;
            endcase
            model(aq, abad, 1'b0, uq, -1, uerr, er, ea, eu);
            run_txn(aq, abad, 1'b0, uq, -1, uerr, o);
            checks++;
            if (!o.ok || o.r !== er || o.a !== ea || o.u !== eu) begin
                errors++;
                $display("FAIL error_case_%0d: got done=%b r=%0d atqa=%h uid=%h want r=%0d atqa=%h uid=%h",
                         k, o.ok, o.r, o.a, o.u, er, ea, eu);
            end
        end
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        int c;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.start = (i == 10);
            @(posedge clk); #1;
            if (tx_now() !== EXP_REQA || bus.busy !== 1'b1) unstable++;
        end
        bus.start = 1'b0;
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable);
        end
        bus.tx_tready = 1'b1;
        @(posedge clk); #1;
        bus.tx_tready = 1'b0;
        wait_for(1'b0, c);
        checks++;
        if (c !== TMO || bus.result !== 2'd1) begin
            errors++;
            $display("FAIL stall_timeout: got %0d cycles r=%0d want %0d r=1", c, bus.result, TMO);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_tvalid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_ignored: got busy=%b tvalid=%b done=%b want 0 0 0",
                     bus.busy, bus.tx_tvalid, bus.done);
        end
    endtask

    task automatic test_tend_on_timeout();
        bq_t uq = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h22};
        logic [13:0] a0, a1;
        int c;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.tx_tready = 1'b1;
        @(posedge clk); #1;
        bus.tx_tready = 1'b0;
        bus.rx_tvalid = 1'b1; bus.rx_tdata = 8'h44; bus.rx_tdatab = 4'd8;
        @(posedge clk); #1;
        bus.rx_tdata = 8'h00;
        @(posedge clk); #1;
        idle_inputs();
        repeat (TMO - 3) begin @(posedge clk); #1; end
        bus.rx_tend = 1'b1;
        @(posedge clk); #1;
        bus.rx_tend = 1'b0;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL tend_on_timeout_wins: got done=%b r=%0d want done 0", bus.done, bus.result);
        end
        wait_for(1'b1, c);
        checks++;
        if (c !== GRD || bus.tx_tvalid !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL tend_on_timeout_guard: got %0d cycles tvalid=%b want %0d", c, bus.tx_tvalid, GRD);
        end
        accept_ac(a0, a1);
        send_rx(uq, -1, 1'b0, 1'b1);
        wait_for(1'b0, c);
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 2'd0 || bus.atqa !== 16'h0044 || bus.uid !== 32'hefbeadde) begin
            errors++;
            $display("FAIL tend_on_timeout_result: got done=%b r=%0d atqa=%h uid=%h want r=0 atqa=0044 uid=efbeadde",
                     bus.done, bus.result, bus.atqa, bus.uid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_uid();
        bq_t aq = '{8'h04, 8'h00};
        bq_t uq;
        logic [13:0] a0, a1;
        int c;
        int saw = 0;
        obs_t o;
        logic [1:0] er; logic [15:0] ea; logic [31:0] eu;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.tx_tready = 1'b1;
        @(posedge clk); #1;
        bus.tx_tready = 1'b0;
        send_rx(aq, -1, 1'b0, 1'b1);
        wait_for(1'b1, c);
        accept_ac(a0, a1);
        bus.rx_tvalid = 1'b1; bus.rx_tdata = 8'h11; bus.rx_tdatab = 4'd8;
        @(posedge clk); #1;
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs_now() !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid_uid_async: got %h want 0", outs_now());
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) saw++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.done || outs_now() !== 66'd0) saw++;
        end
        checks++;
        if (saw != 0) begin
            errors++;
            $display("FAIL reset_mid_uid_no_done: got %0d bad cycles want 0", saw);
        end
        for (int i = 0; i < 4; i++) uq.push_back(8'($urandom));
        uq.push_back(uq[0] ^ uq[1] ^ uq[2] ^ uq[3]);
        model(aq, -1, 1'b0, uq, -1, 1'b0, er, ea, eu);
        run_txn(aq, -1, 1'b0, uq, -1, 1'b0, o);
        checks++;
        if (!o.ok || o.r !== er || o.a !== ea || o.u !== eu) begin
            errors++;
            $display("FAIL reset_then_clean_run: got done=%b r=%0d atqa=%h uid=%h want r=%0d atqa=%h uid=%h",
                     o.ok, o.r, o.a, o.u, er, ea, eu);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            bq_t aq, uq;
            int abad, ubad, sel, n;
            bit aerr, uerr;
            logic [7:0] bcc;
            obs_t o;
            logic [1:0] er; logic [15:0] ea; logic [31:0] eu;
            aq.delete();
            uq.delete();
            sel = $urandom_range(0, 9);
            n = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 0 : 2;
            for (int i = 0; i < n; i++) aq.push_back(8'($urandom));
            abad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            aerr = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 4; i++) uq.push_back(8'($urandom));
            bcc = uq[0] ^ uq[1] ^ uq[2] ^ uq[3];
            if ($urandom_range(0, 2) == 0) bcc = bcc ^ 8'(32'd1 << $urandom_range(0, 7));
            uq.push_back(bcc);
            sel = $urandom_range(0, 11);
            if (sel == 0) void'(uq.pop_back());
            else if (sel == 1) uq.push_back(8'h5a);
            else if (sel == 2) uq.delete();
            ubad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            uerr = ($urandom_range(0, 9) == 0);
            model(aq, abad, aerr, uq, ubad, uerr, er, ea, eu);
            run_txn(aq, abad, aerr, uq, ubad, uerr, o);
            checks++;
            if (!o.ok || o.r !== er || o.a !== ea || o.u !== eu) begin
                errors++;
                $display("FAIL random_%0d: got done=%b r=%0d atqa=%h uid=%h want r=%0d atqa=%h uid=%h",
                         k, o.ok, o.r, o.a, o.u, er, ea, eu);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_no_card();
        test_good_card();
        test_bcc_wrong();
        test_errors();
        test_backpressure();
        test_tend_on_timeout();
        test_reset_mid_uid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nfca_poll_sequencer.md
Name: nfca_poll_sequencer

Overview:
- Sequences one ISO14443-A card-detect transaction over the NFC-A controller's TX/RX byte streams.
- Transaction: send REQA, collect ATQA, wait a guard time, send ANTICOLLISION CL1 (0x93 0x20), collect 4 UID bytes plus BCC, check BCC.
- Sits between the host/soft-CPU command logic and the controller; replaces host-driven byte-level polling.

Parameters:
- TIMEOUT_CYC, 81360: clk cycles allowed from last TX byte accepted to rx_tend (1 ms at 81.36 MHz).
- GUARD_CYC, 8136: idle clk cycles between end of the ATQA frame and the first ANTICOLLISION byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transaction
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the transaction finishes
- result  out  2  0=card UID ok, 1=no response (timeout), 2=RX error/collision/bad length, 3=BCC mismatch; valid while done is high, held until next start
- atqa  out  16  ATQA; first received byte in [7:0]
- uid  out  32  UID CL1; first received byte in [7:0]
- tx_tvalid  out  1  TX byte valid
- tx_tready  in  1  TX byte accepted when tx_tvalid and tx_tready are both high
- tx_tdata  out  8  TX byte
- tx_tdatab  out  4  valid bits in the TX byte, 1..8
- tx_tlast  out  1  last byte of the frame
- rx_tvalid  in  1  RX byte beat
- rx_tdata  in  8  RX byte
- rx_tdatab  in  4  valid bits in the RX byte, 1..8
- rx_tend  in  1  frame-end pulse; may coincide with the final rx_tvalid
- rx_terr  in  1  frame error; sampled only when rx_tend is high

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset asserted mid-transaction returns to IDLE asynchronously. tx_tvalid drops in the same cycle. No done pulse is generated.
- IDLE:
  - start moves to TX_REQA and clears atqa, uid and result.
  - start while busy is ignored.
- TX_REQA:
  - tx_tvalid=1, tx_tdata=0x26, tx_tdatab=7, tx_tlast=1; tx_tvalid rises exactly 1 cycle after start.
  - Outputs hold stable until accepted. On acceptance, clear the timer and the byte count, then go to WAIT_ATQA.
- WAIT_* (both WAIT_ATQA and WAIT_UID):
  - The timer increments every cycle. Reaching TIMEOUT_CYC without rx_tend ends with result=1.
  - Each rx_tvalid stores rx_tdata at the current byte index and increments the count, which saturates at 7. Any byte with rx_tdatab≠8 sets a sticky bad flag.
  - rx_tend with rx_terr=1 ends with result=2.
  - If rx_tend and the timeout occur in the same cycle, rx_tend wins.
  - rx_tvalid with no rx_tend pending is accepted in any WAIT state. RX beats are ignored in all other states.
- WAIT_ATQA, on rx_tend without error:
  - Count must be 2 and the bad flag clear. Then latch atqa, clear the guard counter and go to GUARD.
  - Otherwise end with result=2.
- GUARD: count GUARD_CYC cycles, then go to TX_AC.
- TX_AC:
  - Beat 0: 0x93, tdatab=8, tlast=0. Beat 1: 0x20, tdatab=8, tlast=1.
  - Beat 1 is presented the cycle after beat 0 is accepted. Back-to-back acceptance is allowed.
  - After beat 1 is accepted, clear the timer and byte count and go to WAIT_UID.
- WAIT_UID, on rx_tend without error:
  - Count must be 5 and the bad flag clear, else result=2.
  - If b0^b1^b2^b3 ≠ b4, result=3.
  - Otherwise result=0 and latch uid={b3,b2,b1,b0}.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE. A start in the DONE cycle is ignored.
- Timer width: ceil(log2(TIMEOUT_CYC+1)) bits. The timer never wraps: it stops at TIMEOUT_CYC.

Test Plan:
- No card: start, tx_tready=1, no RX. Expect a REQA beat (0x26/7/last) 1 cycle after start. done comes exactly TIMEOUT_CYC cycles after acceptance, with result=1 and atqa=0.
- Good card: ATQA 0x04,0x00, then UID 0x11,0x22,0x33,0x44 with BCC 0x44. Expect the first AC byte exactly GUARD_CYC cycles after the ATQA rx_tend. Expect atqa=0x0004, uid=0x44332211, result=0.
- BCC wrong: same as above with BCC 0x45. Expect result=3 and uid=0.
- Collision: rx_tend with rx_terr=1 during WAIT_UID → result=2. A 3-byte ATQA → result=2. ATQA byte with rx_tdatab=4 → result=2.
- Backpressure/robustness:
  - Hold tx_tready=0 for 50 cycles: tx_tdata/tx_tvalid stay stable.
  - Pulse start during busy: ignored.
  - rx_tend on the timeout cycle: treated as a response.
  - Assert rst mid-WAIT_UID: all outputs 0, no done pulse. A new start then runs cleanly.
